// File: rtl/ball_mover.sv
// Per-frame ball kinematics: fetches sin/cos of the heading from an external
// table, integrates fixed-point position, clamps at the walls and reflects the heading.
module ball_mover #(
    parameter int THETA_WIDTH = 6,
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 10,
    parameter int FRAC        = 7,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   tick_i,
    input  logic [2:0]             speed_i,
    input  logic                   serve_i,
    input  logic [X_WIDTH-1:0]     serve_x_i,
    input  logic [Y_WIDTH-1:0]     serve_y_i,
    input  logic [THETA_WIDTH-1:0] serve_theta_i,
    output logic [THETA_WIDTH-1:0] theta_o,
    input  logic [7:0]             sin_i,
    output logic [X_WIDTH-1:0]     x_o,
    output logic [Y_WIDTH-1:0]     y_o,
    output logic [THETA_WIDTH-1:0] heading_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   hit_x_o,
    output logic                   hit_y_o
);

    localparam int XW  = X_WIDTH + FRAC;
    localparam int YW  = Y_WIDTH + FRAC;
    localparam int NXW = XW + 2;
    localparam int NYW = YW + 2;

    localparam logic [THETA_WIDTH-1:0] QUARTER = THETA_WIDTH'(32'd1 << (THETA_WIDTH - 2));
    localparam logic [THETA_WIDTH-1:0] HALF    = THETA_WIDTH'(32'd1 << (THETA_WIDTH - 1));

    // First out-of-range value: anything at or above it exceeds the last legal integer position.
    localparam logic signed [NXW-1:0] X_LIM   = NXW'((X_MAX + 32'sd1) << FRAC);
    localparam logic signed [NYW-1:0] Y_LIM   = NYW'((Y_MAX + 32'sd1) << FRAC);
    localparam logic [XW-1:0]         X_CLAMP = XW'(X_MAX << FRAC);
    localparam logic [YW-1:0]         Y_CLAMP = YW'(Y_MAX << FRAC);
    localparam logic [XW-1:0]         X_RST   = XW'((X_MAX / 32'sd2) << FRAC);
    localparam logic [YW-1:0]         Y_RST   = YW'((Y_MAX / 32'sd2) << FRAC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SIN    = 3'd1,
        S_COS    = 3'd2,
        S_MOVE   = 3'd3,
        S_BOUNCE = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [XW-1:0]           xf_q, xf_d;
    logic [YW-1:0]           yf_q, yf_d;
    logic [THETA_WIDTH-1:0]  heading_q, heading_d;
    logic [THETA_WIDTH-1:0]  theta_q, theta_d;
    logic signed [7:0]       s_q, s_d, c_q, c_d;
    logic signed [NXW-1:0]   nx_q, nx_d;
    logic signed [NYW-1:0]   ny_q, ny_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    hit_x_q, hit_x_d;
    logic                    hit_y_q, hit_y_d;

    logic signed [10:0]      dx_s, dy_s;
    logic [XW-1:0]           xf_bounce_s;
    logic [YW-1:0]           yf_bounce_s;
    logic                    hx_s, hy_s;
    logic [THETA_WIDTH-1:0]  heading_bounce_s;

    // Velocity: latched trig values scaled by the unsigned speed (max |127*7| fits 11 bits signed).
    always_comb begin
        dx_s = $signed({{3{c_q[7]}}, c_q}) * $signed({8'd0, speed_i});
        dy_s = $signed({{3{s_q[7]}}, s_q}) * $signed({8'd0, speed_i});
    end

    // Wall clamp and heading reflection applied to the candidate position.
    always_comb begin
        if (nx_q[NXW-1]) begin
            xf_bounce_s = '0;
            hx_s        = 1'b1;
        end else if (nx_q >= X_LIM) begin
            xf_bounce_s = X_CLAMP;
            hx_s        = 1'b1;
        end else begin
            xf_bounce_s = nx_q[XW-1:0];
            hx_s        = 1'b0;
        end
        if (ny_q[NYW-1]) begin
            yf_bounce_s = '0;
            hy_s        = 1'b1;
        end else if (ny_q >= Y_LIM) begin
            yf_bounce_s = Y_CLAMP;
            hy_s        = 1'b1;
        end else begin
            yf_bounce_s = ny_q[YW-1:0];
            hy_s        = 1'b0;
        end
        case ({hx_s, hy_s})
            2'b01:   heading_bounce_s = -heading_q;
            2'b10:   heading_bounce_s = HALF - heading_q;
            2'b11:   heading_bounce_s = heading_q + HALF;
            default: heading_bounce_s = heading_q;
        endcase
    end

    // Next-state and datapath control; serve overrides everything, including a pending tick.
    always_comb begin
        state_d   = state_q;
        xf_d      = xf_q;
        yf_d      = yf_q;
        heading_d = heading_q;
        theta_d   = theta_q;
        s_d       = s_q;
        c_d       = c_q;
        nx_d      = nx_q;
        ny_d      = ny_q;
        done_d    = 1'b0;
        hit_x_d   = 1'b0;
        hit_y_d   = 1'b0;
        if (serve_i) begin
            state_d   = S_IDLE;
            xf_d      = XW'(serve_x_i) << FRAC;
            yf_d      = YW'(serve_y_i) << FRAC;
            heading_d = serve_theta_i;
            theta_d   = serve_theta_i;
        end else begin
            case (state_q)
                S_IDLE: begin
                    theta_d = heading_q;
                    if (tick_i) begin
                        state_d = S_SIN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_SIN: begin
                    s_d     = sin_i;
                    theta_d = heading_q + QUARTER;
                    state_d = S_COS;
                end
                S_COS: begin
                    c_d     = sin_i;
                    theta_d = heading_q;
                    state_d = S_MOVE;
                end
                S_MOVE: begin
                    nx_d    = $signed({2'b00, xf_q}) + $signed({{(NXW-11){dx_s[10]}}, dx_s});
                    ny_d    = $signed({2'b00, yf_q}) + $signed({{(NYW-11){dy_s[10]}}, dy_s});
                    state_d = S_BOUNCE;
                end
                S_BOUNCE: begin
                    xf_d      = xf_bounce_s;
                    yf_d      = yf_bounce_s;
                    heading_d = heading_bounce_s;
                    theta_d   = heading_bounce_s;
                    done_d    = 1'b1;
                    hit_x_d   = hx_s;
                    hit_y_d   = hy_s;
                    state_d   = S_IDLE;
                end
                default: begin
                    theta_d = heading_q;
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            xf_q      <= X_RST;
            yf_q      <= Y_RST;
            heading_q <= '0;
            theta_q   <= '0;
            s_q       <= 8'sd0;
            c_q       <= 8'sd0;
            nx_q      <= '0;
            ny_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_x_q   <= 1'b0;
            hit_y_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            xf_q      <= xf_d;
            yf_q      <= yf_d;
            heading_q <= heading_d;
            theta_q   <= theta_d;
            s_q       <= s_d;
            c_q       <= c_d;
            nx_q      <= nx_d;
            ny_q      <= ny_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hit_x_q   <= hit_x_d;
            hit_y_q   <= hit_y_d;
        end
    end

    assign theta_o   = theta_q;
    assign x_o       = xf_q[XW-1:FRAC];
    assign y_o       = yf_q[YW-1:FRAC];
    assign heading_o = heading_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign hit_x_o   = hit_x_q;
    assign hit_y_o   = hit_y_q;

endmodule

// File: tb/tb_ball_mover.sv
// Directed bench for ball_mover: supplies the sine table, tracks an arithmetic
// model of position/heading and checks every output on each falling edge.
module tb_ball_mover;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [2:0] speed;
    logic       serve;
    logic [9:0] serve_x;
    logic [9:0] serve_y;
    logic [5:0] serve_th;
    logic [5:0] theta_o;
    logic [7:0] sin_s;
    logic [9:0] x_o;
    logic [9:0] y_o;
    logic [5:0] heading_o;
    logic       busy_o, done_o, hit_x_o, hit_y_o;

    logic signed [7:0] sin_tab [64];

    int errors = 0;
    int checks = 0;
    int ndone  = 0;
    bit cmp_en = 0;

    // model state: positions in 1/128 units, heading in table steps
    int mx, my, mh, cnt;
    int px, py, ph;
    bit phx, phy, exp_done, exp_hx, exp_hy;

    ball_mover dut (
        .CLK(clk), .RST(rst), .tick_i(tick), .speed_i(speed),
        .serve_i(serve), .serve_x_i(serve_x), .serve_y_i(serve_y),
        .serve_theta_i(serve_th), .theta_o(theta_o), .sin_i(sin_s),
        .x_o(x_o), .y_o(y_o), .heading_o(heading_o), .busy_o(busy_o),
        .done_o(done_o), .hit_x_o(hit_x_o), .hit_y_o(hit_y_o)
    );

    assign sin_s = sin_tab[theta_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mx = 319 * 128; my = 239 * 128; mh = 0; cnt = 0;
        exp_done = 0; exp_hx = 0; exp_hy = 0;
    endtask

    task automatic predict();
        int sp, sv, cv, nx, ny;
        sp = speed;
        sv = sin_tab[mh];
        cv = sin_tab[(mh + 16) % 64];
        nx = mx + cv * sp;
        ny = my + sv * sp;
        phx = 0; phy = 0;
        if (nx < 0) begin nx = 0; phx = 1; end
        else if (nx > 639 * 128 + 127) begin nx = 639 * 128; phx = 1; end
        if (ny < 0) begin ny = 0; phy = 1; end
        else if (ny > 479 * 128 + 127) begin ny = 479 * 128; phy = 1; end
        if (phx && phy) ph = (mh + 32) & 63;
        else if (phx)   ph = (32 - mh) & 63;
        else if (phy)   ph = (64 - mh) & 63;
        else            ph = mh;
        px = nx; py = ny;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            exp_done = 0; exp_hx = 0; exp_hy = 0;
            if (serve) begin
                mx = int'(serve_x) * 128; my = int'(serve_y) * 128; mh = serve_th; cnt = 0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mx = px; my = py; mh = ph;
                    exp_done = 1; exp_hx = phx; exp_hy = phy;
                end
            end else if (tick) begin
                predict();
                cnt = 4;
            end
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        model_edge();
        #1;
        tick  = 1'b0;
        serve = 1'b0;
    endtask

    task automatic do_serve(input int x, input int y, input int th);
        serve_x = 10'(x); serve_y = 10'(y); serve_th = 6'(th);
        serve = 1'b1;
        clk1();
    endtask

    task automatic run_update();
        tick = 1'b1;
        clk1();
        repeat (4) clk1();
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("x", 32'(x_o), 32'(mx / 128));
            chk("y", 32'(y_o), 32'(my / 128));
            chk("heading", 32'(heading_o), 32'(mh));
            chk("theta", 32'(theta_o), 32'((cnt == 3) ? ((mh + 16) & 63) : mh));
            chk("busy", 32'(busy_o), 32'(cnt > 0));
            chk("done", 32'(done_o), 32'(exp_done));
            chk("hit_x", 32'(hit_x_o), 32'(exp_hx));
            chk("hit_y", 32'(hit_y_o), 32'(exp_hy));
            if (done_o) ndone <= ndone + 1;
        end
    end

    initial begin
        int n0;
        for (int k = 0; k < 64; k++) begin
            real r;
            int  v;
            r = 127.0 * $sin(6.283185307179586 * k / 64.0);
            v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
            sin_tab[k] = 8'(v);
        end
        rst = 1'b1; tick = 1'b0; serve = 1'b0; speed = 3'd0;
        serve_x = 10'd0; serve_y = 10'd0; serve_th = 6'd0;
        model_reset();
        #2;
        chk("rst_x", 32'(x_o), 32'd319);
        chk("rst_y", 32'(y_o), 32'd239);
        chk("rst_theta", 32'(theta_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        repeat (2) clk1();
        rst = 1'b0;
        cmp_en = 1'b1;
        clk1();

        // straight run, no walls
        do_serve(320, 240, 0);
        speed = 3'd1;
        run_update();
        chk("run1_done", 32'(done_o), 32'd1);
        chk("run1_x", 32'(x_o), 32'd320);
        chk("run1_y", 32'(y_o), 32'd240);
        clk1();
        run_update();
        chk("run2_x", 32'(x_o), 32'd321);
        chk("run2_hit", 32'({hit_x_o, hit_y_o}), 32'd0);

        // top wall
        do_serve(100, 3, 48);
        speed = 3'd7;
        run_update();
        chk("top_done", 32'(done_o), 32'd1);
        chk("top_y", 32'(y_o), 32'd0);
        chk("top_heading", 32'(heading_o), 32'd16);
        chk("top_hits", 32'({hit_x_o, hit_y_o}), 32'd1);
        clk1();

        // corner
        do_serve(638, 1, 56);
        speed = 3'd4;
        run_update();
        chk("corner_x", 32'(x_o), 32'd639);
        chk("corner_y", 32'(y_o), 32'd0);
        chk("corner_heading", 32'(heading_o), 32'd24);
        chk("corner_hits", 32'({hit_x_o, hit_y_o}), 32'd3);
        clk1();

        // bottom and left walls, model-checked
        do_serve(100, 479, 16);
        speed = 3'd2;
        run_update();
        clk1();
        do_serve(0, 100, 32);
        speed = 3'd1;
        run_update();
        clk1();

        // theta sequence with wrap
        do_serve(200, 200, 60);
        speed = 3'd2;
        tick = 1'b1;
        clk1();
        chk("theta_sin", 32'(theta_o), 32'd60);
        clk1();
        chk("theta_cos", 32'(theta_o), 32'd12);
        repeat (4) clk1();

        // serve during COS aborts the update
        speed = 3'd3;
        n0 = ndone;
        tick = 1'b1;
        clk1();
        clk1();
        do_serve(50, 60, 5);
        chk("abort_busy", 32'(busy_o), 32'd0);
        chk("abort_x", 32'(x_o), 32'd50);
        chk("abort_y", 32'(y_o), 32'd60);
        chk("abort_heading", 32'(heading_o), 32'd5);
        repeat (6) clk1();
        chk("abort_no_done", 32'(ndone - n0), 32'd0);

        // tick while busy is dropped
        n0 = ndone;
        tick = 1'b1;
        clk1();
        clk1();
        tick = 1'b1;
        clk1();
        repeat (8) clk1();
        chk("one_done_per_tick", 32'(ndone - n0), 32'd1);

        // serve and tick together: serve wins
        serve_x = 10'd10; serve_y = 10'd20; serve_th = 6'd7;
        serve = 1'b1; tick = 1'b1;
        clk1();
        chk("serve_tick_busy", 32'(busy_o), 32'd0);
        repeat (6) clk1();

        // out-of-range serve, clamped by the next update
        do_serve(700, 300, 0);
        chk("oor_x", 32'(x_o), 32'd700);
        speed = 3'd1;
        run_update();
        chk("oor_clamp_x", 32'(x_o), 32'd639);
        chk("oor_heading", 32'(heading_o), 32'd32);
        clk1();

        // asynchronous reset mid-MOVE
        do_serve(400, 400, 10);
        speed = 3'd5;
        tick = 1'b1;
        clk1();
        clk1();
        clk1();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("amid_x", 32'(x_o), 32'd319);
        chk("amid_y", 32'(y_o), 32'd239);
        chk("amid_heading", 32'(heading_o), 32'd0);
        chk("amid_theta", 32'(theta_o), 32'd0);
        chk("amid_busy", 32'(busy_o), 32'd0);
        chk("amid_done", 32'(done_o), 32'd0);
        clk1();
        rst = 1'b0;
        repeat (6) clk1();

        // normal update after reset
        speed = 3'd3;
        run_update();
        clk1();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_mover.md
# ball_mover

Per-frame ball kinematics engine for the pong datapath. It sits directly downstream of the `sin` lookup table. On each frame tick it drives the table's theta input twice, first with the ball heading and then with the heading plus a quarter turn, to get sine and cosine. It scales both by the current speed, accumulates them into fixed-point ball coordinates, and clamps and reflects the heading at the playfield walls. The renderer and paddle-collision logic consume its registered X/Y position and wall-hit pulses.

## Interface
Parameters:
- `THETA_WIDTH`, default 6: heading resolution; 2^THETA_WIDTH steps per full turn. Must match the `sin` instance.
- `X_WIDTH`, default 10: integer width of X position.
- `Y_WIDTH`, default 10: integer width of Y position.
- `FRAC`, default 7: fractional bits of each position accumulator.
- `X_MAX`, default 639: rightmost legal X.
- `Y_MAX`, default 479: bottom legal Y.

Ports:
- `CLK`, in, 1: sole clock, rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `tick_i`, in, 1: one-cycle frame strobe; starts an update.
- `speed_i`, in, 3: unsigned speed multiplier; sampled in the MOVE state.
- `serve_i`, in, 1: one-cycle strobe; loads the serve position and heading.
- `serve_x_i`, in, X_WIDTH: serve X.
- `serve_y_i`, in, Y_WIDTH: serve Y.
- `serve_theta_i`, in, THETA_WIDTH: serve heading.
- `theta_o`, out, THETA_WIDTH: to `sin.theta_i`.
- `sin_i`, in, 8: from `sin.sin_o`; two's complement, combinational off `theta_o`.
- `x_o`, out, X_WIDTH: integer part of X.
- `y_o`, out, Y_WIDTH: integer part of Y.
- `heading_o`, out, THETA_WIDTH: current heading.
- `busy_o`, out, 1: high in every state except IDLE.
- `done_o`, out, 1: one-cycle pulse when an update completes.
- `hit_x_o`, out, 1: one-cycle pulse, coincident with `done_o`, when a left or right wall was hit.
- `hit_y_o`, out, 1: one-cycle pulse, coincident with `done_o`, when the top or bottom wall was hit.

## Operation
- Sine table contract: entry k = round(127·sin(2πk/2^THETA_WIDTH)). Cosine is `sin(heading + 2^(THETA_WIDTH-2))`, with the addition modulo 2^THETA_WIDTH.
- State registers:
  - `xf`: X_WIDTH+FRAC bits, unsigned fixed point.
  - `yf`: Y_WIDTH+FRAC bits, unsigned fixed point.
  - `heading`: THETA_WIDTH bits.
  - `s`, `c`: 8-bit signed latches.
- FSM states:
  - IDLE: `theta_o`=heading. `tick_i` moves to SIN.
  - SIN: `theta_o`=heading; latch `s`←`sin_i`; move to COS.
  - COS: `theta_o`=heading+quarter; latch `c`←`sin_i`; move to MOVE.
  - MOVE:
    - dx = c·speed_i and dy = s·speed_i, each 11-bit signed.
    - nx = xf + sext(dx) and ny = yf + sext(dy), each evaluated signed with 2 extra bits.
    - Register nx and ny, then move to BOUNCE.
  - BOUNCE:
    - X: if nx<0, xf←0; if nx>X_MAX·2^FRAC+(2^FRAC−1), xf←X_MAX·2^FRAC; otherwise xf←nx. Either clamp sets hx.
    - Y: same rule against Y_MAX sets hy.
    - Heading (all arithmetic modulo 2^THETA_WIDTH):
      - hy only: heading←−heading.
      - hx only: heading←half−heading, where half=2^(THETA_WIDTH−1).
      - both: heading←heading+half.
    - Pulse `done_o`, `hit_x_o`=hx, `hit_y_o`=hy; return to IDLE.
- A clamped coordinate has its fraction zeroed.
- `tick_i` outside IDLE is ignored, not queued.
- `serve_i` in any state:
  - Loads xf←serve_x_i·2^FRAC, yf←serve_y_i·2^FRAC, heading←serve_theta_i.
  - Forces IDLE and aborts any update in flight.
  - No `done_o` or hit pulse for the aborted update.
- `serve_i` and `tick_i` in the same cycle: serve wins; the tick is dropped.
- Serve coordinates beyond X_MAX or Y_MAX are loaded unchecked; the next update clamps them.

## Timing
- Reset values:
  - xf = (X_MAX/2)·2^FRAC and yf = (Y_MAX/2)·2^FRAC (integer division), i.e. x_o=319, y_o=239.
  - heading=0, so theta_o=0.
  - FSM in IDLE; `busy_o`, `done_o`, `hit_x_o`, `hit_y_o` all 0.
  - Asserting RST mid-update returns to these values immediately.
- Tick sampled at edge 0:
  - SIN during cycle 1, COS during cycle 2, MOVE during cycle 3, BOUNCE during cycle 4.
  - `done_o`, hits, and new x_o/y_o/heading_o all become visible together after edge 5, and hold until the next update.
  - `busy_o` is high for cycles 1–4.
  - Minimum tick spacing is 5 cycles.
- `x_o`, `y_o` and `heading_o` are registered and change only at the BOUNCE→IDLE edge or on serve.
- `theta_o` is registered and held stable in every state, so `sin_i` has a full cycle to settle.

## Test plan
- Reset: assert RST asynchronously mid-MOVE → outputs immediately x_o=319, y_o=239, heading_o=0, theta_o=0, busy_o=0, no done_o pulse.
- Straight run, no wall contact: serve x=320, y=240, θ=0, speed=1; two ticks → x_o=320 after the first tick (xf=320·128+127) and 321 after the second; y_o stays 240; no hits.
- Top wall: serve y=3, θ=48, speed 7 → dy=−889 → y_o=0, heading_o=16, hit_y_o=1, hit_x_o=0, done_o 5 cycles after the tick.
- Corner hit: serve x=638, y=1, θ=56, speed 4 → x_o=639, y_o=0, heading_o=24, hit_x_o=hit_y_o=1.
- theta_o sequence: heading 60 → theta_o=60 in SIN, 12 in COS (wrap-around).
- Serve abort: serve_i during COS → serve values loaded, FSM in IDLE, no done_o; a tick while busy is ignored (exactly one done_o per accepted tick).
